dp_multicycle_ctrl: RTL
=======================

Name: dp_multicycle_ctrl

Overview:
- Parametrised multi-cycle control unit for the ARMv7 data-processing datapath; drives the datapath's PC, IR, register-file, operand-latch, shift and ALU controls.
- Successor to the fixed 4-state controller. Adds a fetch handshake, condition-code gating, undefined-instruction trap, register-shift operand decode and retired/skipped counters.
- Sits between the IR/NZCV outputs of the datapath and its control inputs inside top_CPU.

Parameters:
- INST_W, 32, instruction width (fixed at 32; the parameter allows checked elaboration only)
- COND_EN, 1, 1 = evaluate Inst[31:28] against NZCV; 0 = execute every instruction
- CNT_W, 16, width of the retired and skipped counters (saturating)

Ports:
- clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-high reset
- Inst  in  INST_W  current IR contents
- NZCV  in  4  flags {N,Z,C,V} from the datapath
- inst_valid  in  1  instruction memory data valid for the current PC
- Write_PC  out  1  PC <= PC+1
- Write_IR  out  1  IR <= memory data
- Write_Reg  out  1  register file write of F to Rd
- LA  out  1  load A latch from Rn
- LB  out  1  load B latch from Rm
- LC  out  1  load C latch from Rs
- LF  out  1  load F latch and, with S, the flags
- rm_imm_s  out  1  0 = Rm operand, 1 = imm8 operand
- rs_imm_s  out  2  shift amount source: 00 = Rs[7:0], 01 = shift_imm Inst[11:7], 10 = rotate_imm*2
- ALU_OP  out  4  = Inst[24:21]
- SHIFT_OP  out  3  {type Inst[6:5], reg-shift Inst[4]}; forced 3'b110 when I=1
- S  out  1  flag update enable
- trap  out  1  sticky undefined-instruction flag
- state  out  3  current state encoding, for debug
- retired_cnt  out  CNT_W  instructions that completed write-back or flag update
- skipped_cnt  out  CNT_W  instructions that failed their condition

Behaviour:
- States: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_WB=4, S_TRAP=5. The state register is updated on the rising edge of clk.
- Reset: Rst=1 at a clock edge forces S_IDLE, trap=0 and both counters=0, and aborts any instruction in flight. Every output is deasserted combinationally while in S_IDLE.
- S_IDLE always moves to S_FETCH on the next edge.
- S_FETCH: holds while inst_valid=0 with all strobes low. When inst_valid=1, Write_IR=1 and Write_PC=1 for exactly that cycle, then the next state is S_DECODE.
- S_DECODE: LA=LB=LC=1 for one cycle.
  - Undefined instruction: Inst[27:26]!=00, or I=0 with Inst[4]=1 and Inst[7]=1, or opcode 10xx with S=0, or Inst[31:28]=1111. Undefined goes to S_TRAP.
  - Condition fail (COND_EN=1): goes to S_FETCH and increments skipped_cnt.
  - Otherwise goes to S_EXEC.
- S_EXEC: LF=1. S=Inst[20]. ALU_OP, SHIFT_OP, rm_imm_s=Inst[25] and rs_imm_s are valid.
  - rs_imm_s = 10 if I=1; 00 if I=0 and Inst[4]=1; otherwise 01.
  - The next state is S_WB.
- S_WB: Write_Reg=1 unless the opcode is TST/TEQ/CMP/CMN (10xx).
  - retired_cnt increments.
  - The next state is S_FETCH.
- Decode outputs (ALU_OP, SHIFT_OP, rm_imm_s, rs_imm_s) are driven in S_DECODE, S_EXEC and S_WB. They are 0 in all other states.
- Total latency per executed instruction: 4 cycles when inst_valid=1 at fetch. A skipped instruction takes 2 cycles.
- Condition codes use standard ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Evaluation uses NZCV sampled in S_DECODE.
- S_TRAP: terminal state. trap=1 and all strobes stay low until Rst.
- Counters saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Package dp_ctrl_pkg holds:
  - state encodings S_*
  - cond codes COND_EQ..COND_AL
  - opcode constants OP_AND..OP_MVN
  - rs_imm_s and SHIFT_OP encodings
  - function cond_pass(cond, nzcv)
- One sub-module, dp_cond_check (combinational, cond + NZCV -> pass). It is bypassed when COND_EN=0.

Test Plan:
- Reset then Inst=0xE0821003 (ADD R1,R2,R3), inst_valid=1 -> the sequence Write_IR/Write_PC, LA/LB/LC, LF (S=0, ALU_OP=0100, rm_imm_s=0, rs_imm_s=01), Write_Reg; retired_cnt=1.
- Inst=0xE2921005 (ADDS R1,R2,#5) -> rm_imm_s=1, rs_imm_s=10, SHIFT_OP=110, S=1 in EXEC, Write_Reg=1.
- Inst=0xE1510002 (CMP R1,R2) -> S=1, ALU_OP=1010, Write_Reg=0 in WB; retired_cnt increments.
- Inst=0x00821003 (ADDEQ) with NZCV=0000 -> DECODE returns to FETCH, no LF or Write_Reg, skipped_cnt=1. Repeat with COND_EN=0 -> executes.
- Inst=0xE1A01312 (MOV R1,R2,LSL R3) -> rs_imm_s=00, SHIFT_OP=001, ALU_OP=1101. Then Inst=0xE7000000 -> S_TRAP, trap=1, all strobes stay low; Rst -> S_IDLE, trap=0, counters=0.
- inst_valid held low 3 cycles in FETCH -> no strobes for those 3 cycles. Rst asserted during S_EXEC -> next cycle S_IDLE with Write_Reg never asserted.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the ARMv7 data-processing multi-cycle controller:
// FSM states, condition codes, opcodes, operand-select codes and condition evaluation.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Shift-amount source select
  localparam logic [1:0] RS_REG   = 2'b00;
  localparam logic [1:0] RS_SHIMM = 2'b01;
  localparam logic [1:0] RS_ROT   = 2'b10;

  // Immediate operands always use the rotate-right path of the shifter
  localparam logic [2:0] SHIFT_IMM_ROT = 3'b110;

  function automatic logic is_compare_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dp_cond_check.sv
// Combinational ARM condition-code check: condition field plus NZCV flags -> pass.
module dp_cond_check
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  assign pass = cond_pass(cond, nzcv);

endmodule

// File: rtl/dp_multicycle_ctrl.sv
// Multi-cycle controller for the ARMv7 data-processing datapath: fetch handshake,
// condition gating, undefined-instruction trap and saturating retired/skipped counters.
module dp_multicycle_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int INST_W  = 32,
  parameter int COND_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [INST_W-1:0] Inst,
  input  logic [3:0]        NZCV,
  input  logic              inst_valid,
  output logic              Write_PC,
  output logic              Write_IR,
  output logic              Write_Reg,
  output logic              LA,
  output logic              LB,
  output logic              LC,
  output logic              LF,
  output logic              rm_imm_s,
  output logic [1:0]        rs_imm_s,
  output logic [3:0]        ALU_OP,
  output logic [2:0]        SHIFT_OP,
  output logic              S,
  output logic              trap,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  skipped_cnt
);

  if (INST_W != 32) begin : g_bad_inst_w
    $error("dp_multicycle_ctrl: INST_W must be 32");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q, state_d;
  logic             trap_q;
  logic [CNT_W-1:0] retired_q, skipped_q;

  logic [3:0] cond_f, opcode_f;
  logic       imm_f, sbit_f, regshift_f, bit7_f;
  logic       cond_ok, undef;

  assign cond_f     = Inst[31:28];
  assign imm_f      = Inst[25];
  assign opcode_f   = Inst[24:21];
  assign sbit_f     = Inst[20];
  assign bit7_f     = Inst[7];
  assign regshift_f = Inst[4];

  // Fields not needed by the controller (register numbers, immediates)
  logic unused_fields;
  assign unused_fields = ^{Inst[19:8], Inst[3:0], NZCV};

  if (COND_EN != 0) begin : g_cond
    dp_cond_check u_cond (
      .cond (cond_f),
      .nzcv (NZCV),
      .pass (cond_ok)
    );
  end else begin : g_nocond
    assign cond_ok = 1'b1;
  end

  // Multiplies/extra load-stores, non-DP classes, flagless compares and the NV space
  assign undef = (Inst[27:26] != 2'b00)
              || (!imm_f && regshift_f && bit7_f)
              || (is_compare_op(opcode_f) && !sbit_f)
              || (cond_f == COND_NV);

  always_ff @(posedge clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (inst_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (undef)         state_d = S_TRAP;
        else if (!cond_ok) state_d = S_FETCH;
        else               state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      trap_q    <= 1'b0;
      retired_q <= '0;
      skipped_q <= '0;
    end else begin
      if (state_q == S_WB)
        retired_q <= sat_inc(retired_q);
      if (state_q == S_DECODE && !undef && !cond_ok)
        skipped_q <= sat_inc(skipped_q);
      if (state_q == S_DECODE && undef)
        trap_q <= 1'b1;
    end
  end

  always_comb begin
    Write_PC  = 1'b0;
    Write_IR  = 1'b0;
    Write_Reg = 1'b0;
    LA        = 1'b0;
    LB        = 1'b0;
    LC        = 1'b0;
    LF        = 1'b0;
    S         = 1'b0;
    rm_imm_s  = 1'b0;
    rs_imm_s  = 2'b00;
    ALU_OP    = 4'h0;
    SHIFT_OP  = 3'b000;
    case (state_q)
      S_FETCH: begin
        Write_PC = inst_valid;
        Write_IR = inst_valid;
      end
      S_DECODE: begin
        LA = 1'b1;
        LB = 1'b1;
        LC = 1'b1;
      end
      S_EXEC: begin
        LF = 1'b1;
        S  = sbit_f;
      end
      S_WB:    Write_Reg = !is_compare_op(opcode_f);
      default: ;
    endcase
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB) begin
      ALU_OP   = opcode_f;
      rm_imm_s = imm_f;
      SHIFT_OP = imm_f ? SHIFT_IMM_ROT : {Inst[6:5], regshift_f};
      if (imm_f)           rs_imm_s = RS_ROT;
      else if (regshift_f) rs_imm_s = RS_REG;
      else                 rs_imm_s = RS_SHIMM;
    end
  end

  assign trap        = (state_q == S_IDLE) ? 1'b0 : trap_q;
  assign state       = state_q;
  assign retired_cnt = retired_q;
  assign skipped_cnt = skipped_q;

endmodule
